// File: rtl/dpram_pkg.sv
`timescale 1ns/1ps
// Shared constants and types for the dual-port RAM emulation arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package dpram_pkg;

    // Arbitration modes
    localparam int ARB_RR    = 0;   // round-robin on conflict
    localparam int ARB_FIXED = 1;   // port A always wins a conflict

    // Port tag carried alongside an in-flight read
    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // Cycles from read grant to RVALID on the requesting port
    localparam int RD_LAT = 2;

    // Bookkeeping for one issued read
    typedef struct packed {
        logic vld;
        logic tag;
    } rd_tag_t;

endpackage

// File: rtl/dpram_rr_arb.sv
`timescale 1ns/1ps
// 2-way arbiter for the shared RAM macro, round-robin or fixed priority.
// Latency: grant is combinational from REQ; the last-grant pointer updates at the clock edge.
// Backpressure: a requester not granted simply keeps REQ high; grants are 0 while RST is high.
//
// Ports: CLK/RST clock and async active-high reset; REQ[0]=A, REQ[1]=B; GNT one-hot or zero.
module dpram_rr_arb
    import dpram_pkg::*;
#(
    parameter int ARB_MODE = ARB_RR
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] REQ,
    output logic [1:0] GNT
);

    // 1 = port B was granted most recently. Reset to B so A wins the first conflict.
    logic last_b;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_b <= 1'b1;
        end else if (|GNT) begin
            last_b <= GNT[1];
        end
    end

    always_comb begin
        GNT = 2'b00;
        if (!RST) begin
            case (REQ)
                2'b01:   GNT = 2'b01;
                2'b10:   GNT = 2'b10;
                2'b11: begin
                    if (ARB_MODE == ARB_FIXED || last_b) GNT = 2'b01;
                    else                                 GNT = 2'b10;
                end
                default: GNT = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dpram_arbiter.sv
`timescale 1ns/1ps
// Emulates a two-port RAM on one single-port RAM_BLOCK macro by arbitrating ports A and B.
// Latency: writes commit at the end of the grant cycle; read data + RVALID arrive RD_LAT cycles after the grant.
// Backpressure: a port holds REQ and its command until GNT (combinational) is seen; one access per cycle.
//
// Ports: CLK, RST (async active-high); per port X in {A,B}: X_REQ, X_WE, X_ADDR, X_WDATA in,
//        X_GNT, X_RVALID, X_RDATA out; macro side RAM_ADDR, RAM_WDATA, RAM_RD_WRN out, RAM_RDATA in.
module dpram_arbiter
    import dpram_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int ARB_MODE = ARB_RR
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          A_REQ,
    input  logic          A_WE,
    input  logic [AW-1:0] A_ADDR,
    input  logic [DW-1:0] A_WDATA,
    output logic          A_GNT,
    output logic          A_RVALID,
    output logic [DW-1:0] A_RDATA,
    input  logic          B_REQ,
    input  logic          B_WE,
    input  logic [AW-1:0] B_ADDR,
    input  logic [DW-1:0] B_WDATA,
    output logic          B_GNT,
    output logic          B_RVALID,
    output logic [DW-1:0] B_RDATA,
    output logic [AW-1:0] RAM_ADDR,
    output logic [DW-1:0] RAM_WDATA,
    output logic          RAM_RD_WRN,
    input  logic [DW-1:0] RAM_RDATA
);

    logic [1:0] gnt;

    dpram_rr_arb #(
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .CLK (CLK),
        .RST (RST),
        .REQ ({B_REQ, A_REQ}),
        .GNT (gnt)
    );

    assign A_GNT = gnt[0];
    assign B_GNT = gnt[1];

    // Macro drive: the winner's command, otherwise a harmless read of address 0.
    always_comb begin
        RAM_ADDR   = '0;
        RAM_WDATA  = '0;
        RAM_RD_WRN = 1'b1;
        if (gnt[0]) begin
            RAM_ADDR   = A_ADDR;
            RAM_WDATA  = A_WDATA;
            RAM_RD_WRN = ~A_WE;
        end else if (gnt[1]) begin
            RAM_ADDR   = B_ADDR;
            RAM_WDATA  = B_WDATA;
            RAM_RD_WRN = ~B_WE;
        end
    end

    // Read tag pipeline. The macro registers RDATA one edge after the grant, so the
    // tag travels RD_LAT-1 stages and the last stage steers the capture into the port register.
    rd_tag_t                issue_tag;
    rd_tag_t [RD_LAT-2:0]   tag_q;
    rd_tag_t                done_tag;

    always_comb begin
        issue_tag.vld = (gnt[0] & ~A_WE) | (gnt[1] & ~B_WE);
        issue_tag.tag = gnt[1] ? PORT_B : PORT_A;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tag_q <= '0;
        end else begin
            tag_q[0] <= issue_tag;
            for (int i = 1; i < RD_LAT - 1; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign done_tag = tag_q[RD_LAT-2];

    // Per-port result registers: RDATA only changes when that port's own read completes.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            A_RVALID <= 1'b0;
            B_RVALID <= 1'b0;
            A_RDATA  <= '0;
            B_RDATA  <= '0;
        end else begin
            A_RVALID <= done_tag.vld && (done_tag.tag == PORT_A);
            B_RVALID <= done_tag.vld && (done_tag.tag == PORT_B);
            if (done_tag.vld && (done_tag.tag == PORT_A)) A_RDATA <= RAM_RDATA;
            if (done_tag.vld && (done_tag.tag == PORT_B)) B_RDATA <= RAM_RDATA;
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
`timescale 1ns/1ps
// Directed bench for dpram_arbiter: one round-robin and one fixed-priority instance
// share the request inputs; each has its own single-port RAM model.
module tb_dpram_arbiter;
    import dpram_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #1 clk = ~clk;   // 2 ns period

    logic       a_req, a_we, b_req, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;

    logic       r_a_gnt, r_a_rvalid, r_b_gnt, r_b_rvalid, r_ram_rd_wrn;
    logic [7:0] r_a_rdata, r_b_rdata, r_ram_addr, r_ram_wdata, r_ram_rdata;
    logic       f_a_gnt, f_a_rvalid, f_b_gnt, f_b_rvalid, f_ram_rd_wrn;
    logic [7:0] f_a_rdata, f_b_rdata, f_ram_addr, f_ram_wdata, f_ram_rdata;

    logic [7:0] r_mem [256];
    logic [7:0] f_mem [256];

    dpram_arbiter #(.AW(8), .DW(8), .ARB_MODE(ARB_RR)) u_rr (
        .CLK(clk), .RST(rst),
        .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
        .A_GNT(r_a_gnt), .A_RVALID(r_a_rvalid), .A_RDATA(r_a_rdata),
        .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
        .B_GNT(r_b_gnt), .B_RVALID(r_b_rvalid), .B_RDATA(r_b_rdata),
        .RAM_ADDR(r_ram_addr), .RAM_WDATA(r_ram_wdata),
        .RAM_RD_WRN(r_ram_rd_wrn), .RAM_RDATA(r_ram_rdata)
    );

    dpram_arbiter #(.AW(8), .DW(8), .ARB_MODE(ARB_FIXED)) u_fx (
        .CLK(clk), .RST(rst),
        .A_REQ(a_req), .A_WE(a_we), .A_ADDR(a_addr), .A_WDATA(a_wdata),
        .A_GNT(f_a_gnt), .A_RVALID(f_a_rvalid), .A_RDATA(f_a_rdata),
        .B_REQ(b_req), .B_WE(b_we), .B_ADDR(b_addr), .B_WDATA(b_wdata),
        .B_GNT(f_b_gnt), .B_RVALID(f_b_rvalid), .B_RDATA(f_b_rdata),
        .RAM_ADDR(f_ram_addr), .RAM_WDATA(f_ram_wdata),
        .RAM_RD_WRN(f_ram_rd_wrn), .RAM_RDATA(f_ram_rdata)
    );

    // Single-port RAM macro models: registered read, RDATA held during writes.
    initial begin
        r_ram_rdata = 8'h00;
        f_ram_rdata = 8'h00;
        for (int i = 0; i < 256; i++) begin
            r_mem[i] = 8'h00;
            f_mem[i] = 8'h00;
        end
    end

    always @(posedge clk) begin
        if (!r_ram_rd_wrn) r_mem[r_ram_addr] <= r_ram_wdata;
        else               r_ram_rdata       <= r_mem[r_ram_addr];
        if (!f_ram_rd_wrn) f_mem[f_ram_addr] <= f_ram_wdata;
        else               f_ram_rdata       <= f_mem[f_ram_addr];
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called right after a negedge; settles combinational outputs before returning.
    task automatic drive(input logic ar, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                         input logic br, input logic bw, input logic [7:0] ba, input logic [7:0] bd);
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        #0.2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    initial begin
        idle();

        // 1. Reset with both requesting, then release
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
        check("rst_a_gnt",    r_a_gnt,      1'b0);
        check("rst_b_gnt",    r_b_gnt,      1'b0);
        check("rst_f_a_gnt",  f_a_gnt,      1'b0);
        check("rst_a_rvalid", r_a_rvalid,   1'b0);
        check("rst_b_rvalid", r_b_rvalid,   1'b0);
        check("rst_rd_wrn",   r_ram_rd_wrn, 1'b1);
        check("rst_ram_addr", r_ram_addr,   8'h00);
        check("rst_a_rdata",  r_a_rdata,    8'h00);
        @(negedge clk);
        rst = 1'b0;
        #0.2;
        check("rel_a_gnt", r_a_gnt, 1'b1);
        check("rel_b_gnt", r_b_gnt, 1'b0);
        @(negedge clk); idle();
        repeat (3) @(negedge clk);

        // 2. A write 0x10<=0x5A then A read 0x10
        drive(1'b1, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t2_wr_gnt",    r_a_gnt,      1'b1);
        check("t2_wr_rd_wrn", r_ram_rd_wrn, 1'b0);
        check("t2_wr_addr",   r_ram_addr,   8'h10);
        check("t2_wr_wdata",  r_ram_wdata,  8'h5A);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t2_rd_gnt", r_a_gnt, 1'b1);
        @(negedge clk);
        check("t2_rv_early", r_a_rvalid, 1'b0);
        idle();
        @(negedge clk);
        check("t2_rv",    r_a_rvalid, 1'b1);
        check("t2_rdata", r_a_rdata,  8'h5A);
        check("t2_b_rv",  r_b_rvalid, 1'b0);
        @(negedge clk);
        check("t2_rv_end", r_a_rvalid, 1'b0);

        // 3. Round-robin with both holding reads; preload 0x30=0x11 (A), 0x40=0x22 (B)
        drive(1'b1, 1'b1, 8'h30, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h40, 8'h22);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("t3_a_rv%0d", c), r_a_rvalid, (c == 2 || c == 4));
            check($sformatf("t3_b_rv%0d", c), r_b_rvalid, (c == 3 || c == 5));
            if (c >= 2) check($sformatf("t3_a_rdata%0d", c), r_a_rdata, 8'h11);
            if (c >= 3) check($sformatf("t3_b_rdata%0d", c), r_b_rdata, 8'h22);
            if (c < 4) begin
                drive(1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b0, 8'h40, 8'h00);
                check($sformatf("t3_a_gnt%0d", c), r_a_gnt, (c % 2 == 0));
                check($sformatf("t3_b_gnt%0d", c), r_b_gnt, (c % 2 == 1));
            end else begin
                idle();
            end
        end

        // 4a. Pointer favours A: A reads old 0x77, B's write of 0xC3 follows
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h77);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 8'h20, 8'hC3);
        check("t4a_a_gnt", r_a_gnt, 1'b1);
        check("t4a_b_gnt", r_b_gnt, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'hC3);
        check("t4a_b_gnt2", r_b_gnt, 1'b1);
        @(negedge clk);
        check("t4a_a_rv",    r_a_rvalid, 1'b1);
        check("t4a_a_rdata", r_a_rdata,  8'h77);
        idle();

        // 4b. Restore 0x77 via A (pointer now favours B): write goes first, A reads 0xC3
        @(negedge clk);
        drive(1'b1, 1'b1, 8'h20, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 8'h20, 8'hC3);
        check("t4b_b_gnt", r_b_gnt, 1'b1);
        check("t4b_a_gnt", r_a_gnt, 1'b0);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t4b_a_gnt2", r_a_gnt, 1'b1);
        @(negedge clk);
        check("t4b_a_rv_early", r_a_rvalid, 1'b0);
        idle();
        @(negedge clk);
        check("t4b_a_rv",    r_a_rvalid, 1'b1);
        check("t4b_a_rdata", r_a_rdata,  8'hC3);

        // 5. Fixed priority: A held 5 cycles, B held throughout
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 5) drive(1'b1, 1'b0, 8'(c), 8'h00, 1'b1, 1'b0, 8'h60, 8'h00);
            else       drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h60, 8'h00);
            check($sformatf("t5_f_a_gnt%0d", c), f_a_gnt, (c < 5));
            check($sformatf("t5_f_b_gnt%0d", c), f_b_gnt, (c == 5));
        end
        @(negedge clk); idle();
        repeat (3) @(negedge clk);

        // 6. Write 0x50<=0xA5, read 0x50, reset pulse kills the read
        drive(1'b1, 1'b1, 8'h50, 8'hA5, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t6_wr_gnt", r_a_gnt, 1'b1);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t6_rd_gnt", r_a_gnt, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t6_rst_gnt", r_a_gnt, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        check("t6_rv0",    r_a_rvalid, 1'b0);
        check("t6_rdata0", r_a_rdata,  8'h00);
        @(negedge clk);
        check("t6_rv1",    r_a_rvalid, 1'b0);
        check("t6_rdata1", r_a_rdata,  8'h00);
        @(negedge clk);
        drive(1'b1, 1'b0, 8'h50, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
        check("t6_rd2_gnt", r_a_gnt, 1'b1);
        @(negedge clk);
        idle();
        @(negedge clk);
        check("t6_rv2",    r_a_rvalid, 1'b1);
        check("t6_rdata2", r_a_rdata,  8'hA5);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
